// File: rtl/fetch_pkg.sv
// Shared definitions for the UART instruction fetcher:
// state encoding, byte width and the default fetch command.
package fetch_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] CMD_FETCH_DEF = 8'h03;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX_CMD = 3'd1,
        W_CMD  = 3'd2,
        TX_ADR = 3'd3,
        W_ADR  = 3'd4,
        RX_HI  = 3'd5,
        RX_LO  = 3'd6,
        DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Per-byte response timeout counter; saturates at the terminal count.
// Clear takes priority over enable.
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter int TO_W        = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/uart_instr_fetcher.sv
// Fetches one 16-bit instruction over UART: sends command and PC,
// then receives hi/lo bytes, with timeout, bounded retry and hold.
module uart_instr_fetcher
    import fetch_pkg::*;
#(
    parameter logic [BYTE_W-1:0] CMD_FETCH = CMD_FETCH_DEF,
    parameter int TIMEOUT_CYC = 20000,
    parameter int MAX_RETRY   = 3,
    parameter int TO_W        = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] address,
    input  logic              hold,
    input  logic              rx_done,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic [15:0]       instruction,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int RT_W = $clog2(MAX_RETRY + 1);

    state_t            state, state_nx;
    logic [RT_W-1:0]   retry, retry_nx;
    logic [BYTE_W-1:0] addr, addr_nx;
    logic [BYTE_W-1:0] hi, hi_nx;
    logic [BYTE_W-1:0] tx_data_nx;
    logic [15:0]       instr_nx;
    logic              tx_start_nx, done_nx, err_nx;
    logic              in_rx, rx_ok, tc;

    assign in_rx = (state == RX_HI) || (state == RX_LO);
    assign rx_ok = in_rx && rx_done && !hold;
    assign busy  = (state != IDLE);

    fetch_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_to (
        .clk   (clk),
        .reset (reset),
        .clear (!in_rx || rx_ok),
        .enable(in_rx && !hold),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            retry       <= '0;
            addr        <= '0;
            hi          <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            instruction <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            retry       <= retry_nx;
            addr        <= addr_nx;
            hi          <= hi_nx;
            tx_start    <= tx_start_nx;
            tx_data     <= tx_data_nx;
            instruction <= instr_nx;
            done        <= done_nx;
            err         <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        retry_nx    = retry;
        addr_nx     = addr;
        hi_nx       = hi;
        tx_start_nx = 1'b0;
        tx_data_nx  = tx_data;
        instr_nx    = instruction;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        if (!hold) begin
            unique case (state)
                IDLE: if (start) begin
                    addr_nx  = address;
                    retry_nx = '0;
                    state_nx = TX_CMD;
                end
                TX_CMD: begin
                    tx_start_nx = 1'b1;
                    tx_data_nx  = CMD_FETCH;
                    state_nx    = W_CMD;
                end
                W_CMD: if (tx_done) state_nx = TX_ADR;
                TX_ADR: begin
                    tx_start_nx = 1'b1;
                    tx_data_nx  = addr;
                    state_nx    = W_ADR;
                end
                W_ADR: if (tx_done) state_nx = RX_HI;
                RX_HI: if (rx_done) begin
                    hi_nx    = rx_data;
                    state_nx = RX_LO;
                end
                RX_LO: if (rx_done) begin
                    instr_nx = {hi, rx_data};
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
            // A byte arriving on the terminal cycle beats the timeout
            if (in_rx && !rx_done && tc) begin
                if (retry < RT_W'(MAX_RETRY)) begin
                    retry_nx = retry + 1'b1;
                    state_nx = TX_CMD;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
        end
    end

endmodule
